// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DZ   = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial
// remainder, then restore-or-keep and shift the next quotient bit into q.
module div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q_bit_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   divisor_n;
    logic [WIDTH+1:0] sum;
    logic             no_borrow;
    logic             unused_sum_msb;

    // The shifted remainder can exceed 2^WIDTH-1, so the subtract needs WIDTH+1 bits.
    // It is formed as an add of the inverted divisor with carry-in 1; carry-out is no-borrow.
    assign shifted   = {r_i, q_i[WIDTH-1]};
    assign divisor_n = ~{1'b0, divisor_i};
    assign sum       = {1'b0, shifted} + {1'b0, divisor_n} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign no_borrow = sum[WIDTH+1];

    assign unused_sum_msb = sum[WIDTH];

    always_comb begin
        r_o     = no_borrow ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_o     = {q_i[WIDTH-2:0], no_borrow};
        q_bit_o = no_borrow;
    end

endmodule

// File: rtl/seq_div_16b.sv
// Sequential unsigned radix-2 restoring divider with start/done handshake.
// One quotient bit per clock; divide-by-zero is short-circuited through the DZ state.
module seq_div_16b
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] q_reg_q, q_reg_d;
    logic [WIDTH-1:0] r_reg_q, r_reg_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;
    logic             unused_step_bit;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r_i      (r_reg_q),
        .q_i      (q_reg_q),
        .divisor_i(dvsr_q),
        .r_o      (step_r),
        .q_o      (step_q),
        .q_bit_o  (unused_step_bit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_reg_d     = q_reg_q;
        r_reg_d     = r_reg_q;
        dvsr_d      = dvsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // q_reg also carries the dividend into DZ as the remainder.
                    q_reg_d = dividend;
                    if (divisor != '0) begin
                        state_d = RUN;
                        dvsr_d  = divisor;
                        r_reg_d = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = DZ;
                    end
                end
            end
            RUN: begin
                q_reg_d = step_q;
                r_reg_d = step_r;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    quotient_d  = step_q;
                    remainder_d = step_r;
                    dz_d        = 1'b0;
                    done_d      = 1'b1;
                end
            end
            DZ: begin
                state_d     = IDLE;
                quotient_d  = '1;
                remainder_d = q_reg_q;
                dz_d        = 1'b1;
                done_d      = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            q_reg_q     <= '0;
            r_reg_q     <= '0;
            dvsr_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_reg_q     <= q_reg_d;
            r_reg_q     <= r_reg_d;
            dvsr_q      <= dvsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_div_16b.sv
// Scoreboard bench for seq_div_16b: driver pushes reference results, a negedge monitor
// pops and compares on every done pulse.
module tb_seq_div_16b;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    seq_div_16b #(
        .WIDTH(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dd;
        logic [15:0] dv;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer division, all-ones/dividend for a zero divisor.
    function automatic exp_t model(input logic [15:0] dd, input logic [15:0] dv);
        exp_t e;
        e.dd = dd;
        e.dv = dv;
        if (dv == 16'd0) begin
            e.q  = 16'hFFFF;
            e.r  = dd;
            e.dz = 1'b1;
        end else begin
            e.q  = 16'(int'(dd) / int'(dv));
            e.r  = 16'(int'(dd) % int'(dv));
            e.dz = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no result pending at %0t",
                         $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                if (e.dv != 16'd0) begin
                    chk("invariant", 32'(quotient) * 32'(e.dv) + 32'(remainder), 32'(e.dd));
                    chk("rem_lt_div", 32'(remainder < e.dv), 32'd1);
                end
            end
        end
    end

    task automatic issue(input logic [15:0] dd, input logic [15:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        sb.push_back(model(dd, dv));
    endtask

    // Counts negedges until done; lat is the negedge index of the done cycle.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL done_timeout: got no done in 60 cycles, expected a done pulse");
    endtask

    task automatic run_op(input logic [15:0] dd, input logic [15:0] dv);
        int lat;
        int bc;
        @(posedge clk);
        #1;
        issue(dd, dv);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        chk("latency", 32'(lat), (dv == 16'd0) ? 32'd2 : 32'd17);
        chk("busy_cycles", 32'(bc), (dv == 16'd0) ? 32'd0 : 32'd16);
    endtask

    initial begin
        int lat;
        int bc;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_dz", 32'(div_by_zero), 32'd0);

        run_op(16'd100, 16'd7);
        run_op(16'hFFFF, 16'h0001);
        run_op(16'hFFFF, 16'hFFFF);
        run_op(16'h8000, 16'h0003);
        run_op(16'd3, 16'd10);
        run_op(16'd0, 16'd5);
        run_op(16'd1234, 16'd0);
        run_op(16'd9, 16'd2);

        // Starts during RUN are ignored; a start held in the done cycle is accepted.
        @(posedge clk);
        #1;
        issue(16'd50000, 16'd13);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start    = (c == 3 || c == 8);
            dividend = 16'($urandom);
            divisor  = 16'($urandom_range(1, 65535));
        end
        start = 1'b0;
        wait_done(lat, bc);
        issue(16'd40000, 16'd7);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        chk("b2b_done_spacing", 32'(lat), 32'd17);

        // Reset mid-RUN after leaving a divide-by-zero result in the output registers.
        run_op(16'd1234, 16'd0);
        @(posedge clk);
        #1;
        issue(16'd777, 16'd5);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrun_reset_busy", 32'(busy), 32'd0);
        chk("midrun_reset_done", 32'(done), 32'd0);
        chk("midrun_reset_quotient", 32'(quotient), 32'd0);
        chk("midrun_reset_remainder", 32'(remainder), 32'd0);
        chk("midrun_reset_dz", 32'(div_by_zero), 32'd0);
        bc = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) bc++;
        end
        chk("no_done_after_reset", 32'(bc), 32'd0);
        run_op(16'd9, 16'd2);

        for (int i = 0; i < 2000; i++) begin
            logic [15:0] dd;
            logic [15:0] dv;
            int          sel;
            sel = int'($urandom_range(0, 9));
            dd  = (sel == 9) ? 16'($urandom_range(0, 300)) : 16'($urandom);
            if (sel == 0)      dv = 16'd0;
            else if (sel <= 3) dv = 16'($urandom_range(1, 255));
            else               dv = 16'($urandom);
            run_op(dd, dv);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
